// File: rtl/vector_checker.sv
// vector_checker -- in-order response checker for a datapath output.
//
// Expected result words are queued in a small FIFO, which accepts pushes in
// every state. While a run is active, each observed word is compared against
// the FIFO head. The checker keeps pass/fail/unexpected counters and captures
// the first mismatch of the run.
//
// Optional feature: define VECTOR_CHECKER_TIMEOUT_EN to build a watchdog. The
// watchdog ends a run when expected data sits in the FIFO for TIMEOUT cycles
// with no observation.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start, i_num_vec      arm a run of i_num_vec comparisons (IDLE/DONE only)
//   i_exp_valid, i_exp_data expected word in, handshake with o_exp_ready
//   o_exp_ready             FIFO not full
//   i_obs_valid, i_obs_data observed word (no backpressure)
//   o_busy, o_done, o_pass  run status; o_pass meaningful while o_done
//   o_pass_cnt, o_fail_cnt, o_unexp_cnt  run counters (saturating)
//   o_first_fail_idx/_exp/_obs          first mismatch capture
//   o_timeout               watchdog fired (always 0 without the watchdog)
module vector_checker #(
  parameter int DATAWIDTH = 64,
  parameter int DEPTH     = 8,
  parameter int CNTWIDTH  = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CNTWIDTH-1:0]  i_num_vec,
  input  logic                 i_exp_valid,
  input  logic [DATAWIDTH-1:0] i_exp_data,
  output logic                 o_exp_ready,
  input  logic                 i_obs_valid,
  input  logic [DATAWIDTH-1:0] i_obs_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [CNTWIDTH-1:0]  o_pass_cnt,
  output logic [CNTWIDTH-1:0]  o_fail_cnt,
  output logic [CNTWIDTH-1:0]  o_unexp_cnt,
  output logic [CNTWIDTH-1:0]  o_first_fail_idx,
  output logic [DATAWIDTH-1:0] o_first_fail_exp,
  output logic [DATAWIDTH-1:0] o_first_fail_obs,
  output logic                 o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // FIFO storage. The head must be visible combinationally so that an
  // observation can be compared in the cycle it arrives; at this depth the
  // array maps to distributed RAM.
  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [AW:0]          w_level;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DATAWIDTH-1:0] w_head;

  logic [CNTWIDTH-1:0]  r_num_vec;
  logic [CNTWIDTH-1:0]  r_pass_cnt;
  logic [CNTWIDTH-1:0]  r_fail_cnt;
  logic [CNTWIDTH-1:0]  r_unexp_cnt;
  logic [CNTWIDTH-1:0]  r_ff_idx;
  logic [DATAWIDTH-1:0] r_ff_exp;
  logic [DATAWIDTH-1:0] r_ff_obs;

  logic [CNTWIDTH:0]    w_done_cnt;
  logic                 w_quota_met;
  logic                 w_start_ok;
  logic                 w_obs_en;
  logic                 w_unexp;
  logic                 w_match;
  logic                 w_wd_hit;
  logic                 w_timeout;

  // Occupancy uses pointers that carry one extra wrap bit.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == LVL_FULL);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_done_cnt  = {1'b0, r_pass_cnt} + {1'b0, r_fail_cnt};
  assign w_quota_met = (w_done_cnt == {1'b0, r_num_vec});
  assign w_start_ok  = i_start && (r_state != S_RUN);

  // Once the quota is reached, the run is complete. Observations arriving
  // during the cycle before DONE are therefore not counted.
  assign w_obs_en = (r_state == S_RUN) && i_obs_valid && !w_quota_met;
  assign w_pop    = w_obs_en && !w_empty;
  assign w_unexp  = w_obs_en && w_empty;
  // A refused push while full holds even if a pop happens in the same cycle.
  assign w_push   = i_exp_valid && !w_full;
  assign w_match  = (w_head == i_obs_data);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_exp_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        // An empty run has nothing to wait for.
        if (i_start) w_state_next = (i_num_vec == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_quota_met || w_wd_hit) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_num_vec   <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_unexp_cnt <= '0;
      r_ff_idx    <= '0;
      r_ff_exp    <= '0;
      r_ff_obs    <= '0;
    end else if (w_start_ok) begin
      r_num_vec   <= i_num_vec;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_unexp_cnt <= '0;
      r_ff_idx    <= '0;
      r_ff_exp    <= '0;
      r_ff_obs    <= '0;
    end else begin
      if (w_pop) begin
        if (w_match) begin
          if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
        end else begin
          if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
          // The fail counter saturates instead of wrapping, so zero means
          // no mismatch has been seen yet in this run.
          if (r_fail_cnt == '0) begin
            r_ff_idx <= w_done_cnt[CNTWIDTH-1:0];
            r_ff_exp <= w_head;
            r_ff_obs <= i_obs_data;
          end
        end
      end
      if (w_unexp && (r_unexp_cnt != '1)) r_unexp_cnt <= r_unexp_cnt + 1'b1;
    end
  end

`ifdef VECTOR_CHECKER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  logic [WDW-1:0] r_wd;
  logic           r_timeout;

  // The watchdog counts only while data is waiting and nothing is observed.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != S_RUN) || i_obs_valid || w_empty) begin
      r_wd <= '0;
    end else if (r_wd != WD_LIMIT) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign w_wd_hit = (r_state == S_RUN) && (r_wd == WD_LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_ok) begin
      r_timeout <= 1'b0;
    end else if (w_wd_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign w_timeout = r_timeout;
`else
  // Without the watchdog, a run waits for observations indefinitely.
  // TIMEOUT is accepted for interface compatibility but has no effect here.
  assign w_wd_hit  = 1'b0;
  assign w_timeout = (TIMEOUT < 0);
`endif

  assign o_exp_ready      = !w_full;
  assign o_busy           = (r_state == S_RUN);
  assign o_done           = (r_state == S_DONE);
  assign o_pass           = o_done && (r_fail_cnt == '0) && (r_unexp_cnt == '0) && !w_timeout;
  assign o_pass_cnt       = r_pass_cnt;
  assign o_fail_cnt       = r_fail_cnt;
  assign o_unexp_cnt      = r_unexp_cnt;
  assign o_first_fail_idx = r_ff_idx;
  assign o_first_fail_exp = r_ff_exp;
  assign o_first_fail_obs = r_ff_obs;
  assign o_timeout        = w_timeout;

endmodule
